ram_scan_reader: RTL

Read-side companion to the Fibonacci RAM writer. It scans the single-port character RAM from address 0 to DEPTH-1, one read per `enable` tick from `slowdown_unit`, and streams each captured word out on a valid/ready interface, with `last` marking the final word. It shares the RAM port protocol of the writer: address sampled on the clock edge, data valid one cycle later. An optional binary-to-BCD stage formats each word for display.

---
 rtl/ram_scan_reader_pkg.sv | 29 ++
 rtl/ram_scan_reader_if.sv | 25 ++
 rtl/ram_scan_reader_bin2bcd_seq.sv | 66 ++++++
 rtl/ram_scan_reader.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ram_scan_reader_pkg.sv
// Shared types and constants for the RAM scan reader and its BCD converter.
// Macro RAM_SCAN_READER_BCD_EN adds the CONV state to the FSM enum.
package ram_scan_pkg;

  localparam int unsigned BCD_W    = 12;
  localparam int unsigned DD_ITERS = 8;
  localparam int unsigned DD_IN_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPT,
`ifdef RAM_SCAN_READER_BCD_EN
    CONV,
`endif
    PRESENT
  } state_e;

  // One double-dabble iteration: add 3 to each nibble >= 5, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd, input logic bin_msb);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int n = 0; n < int'(BCD_W / 4); n++) begin
      if (bcd[4*n +: 4] >= 4'd5) adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], bin_msb};
  endfunction

endpackage

// File: rtl/ram_scan_reader_if.sv
// RAM read port plus valid/ready output stream of the scan reader.
interface ram_scan_reader_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) ();

  logic [ADDR_W-1:0]               ram_addr;
  logic                            ram_re;
  logic [DATA_W-1:0]               ram_dout;
  logic                            out_valid;
  logic                            out_ready;
  logic [ram_scan_pkg::BCD_W-1:0]  out_data;
  logic                            out_last;

  modport master (
    output ram_addr, ram_re, out_valid, out_data, out_last,
    input  ram_dout, out_ready
  );

  modport slave (
    input  ram_addr, ram_re, out_valid, out_data, out_last,
    output ram_dout, out_ready
  );

endinterface

// File: rtl/ram_scan_reader_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one bit per cycle).
// Compiled only when RAM_SCAN_READER_BCD_EN is defined.
`ifdef RAM_SCAN_READER_BCD_EN
module bin2bcd_seq
  import ram_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DD_IN_W-1:0] din,
  output logic               done,
  output logic [BCD_W-1:0]   dout
);

  localparam int unsigned CNT_W = 4;

  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [DD_IN_W-1:0] bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               done_q, done_d;

  // The first iteration is folded into the start cycle so the result lands after DD_ITERS cycles.
  always_comb begin
    bcd_d  = bcd_q;
    bin_d  = bin_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      bcd_d = dd_step('0, din[DD_IN_W-1]);
      bin_d = {din[DD_IN_W-2:0], 1'b0};
      cnt_d = CNT_W'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = dd_step(bcd_q, bin_q[DD_IN_W-1]);
      bin_d = {bin_q[DD_IN_W-2:0], 1'b0};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DD_ITERS - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign dout = bcd_q;

endmodule
`endif

// File: rtl/ram_scan_reader.sv
// Scans the character RAM from 0 to DEPTH-1 and streams each word out on valid/ready.
// Define RAM_SCAN_READER_BCD_EN to format words as three BCD digits.
module ram_scan_reader
  import ram_scan_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 start,
  output logic                 busy,
  ram_scan_reader_if.master    bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [BCD_W-1:0]   out_data_q, out_data_d;

`ifdef RAM_SCAN_READER_BCD_EN
  logic               conv_start;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_dout;

  if (DATA_W != 8) begin : g_bad_data_w
    $error("ram_scan_reader: BCD formatting requires DATA_W == 8");
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .din   (DD_IN_W'(bus.ram_dout)),
    .done  (conv_done),
    .dout  (conv_dout)
  );
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
`ifdef RAM_SCAN_READER_BCD_EN
    conv_start  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (enable) state_d = CAPT;
      end
      CAPT: begin
        out_data_d = BCD_W'(bus.ram_dout);
`ifdef RAM_SCAN_READER_BCD_EN
        conv_start = 1'b1;
        state_d    = CONV;
`else
        out_valid_d = 1'b1;
        out_last_d  = (idx_q == LAST_IDX);
        state_d     = PRESENT;
`endif
      end
`ifdef RAM_SCAN_READER_BCD_EN
      CONV: begin
        if (conv_done) begin
          out_data_d  = conv_dout;
          out_valid_d = 1'b1;
          out_last_d  = (idx_q == LAST_IDX);
          state_d     = PRESENT;
        end
      end
`endif
      PRESENT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // RAM port follows the state directly so the read lands on the enable cycle itself.
  assign bus.ram_re    = (state_q == ISSUE) && enable;
  assign bus.ram_addr  = (state_q == IDLE) ? '0 : idx_q;

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;

endmodule
